inst_queue: RTL and testbench
=============================

Name: inst_queue

Overview:
Dual-slot instruction queue between the fetch stage and ID1 decode, i.e. directly upstream of the ID1→issue pipeline register.
- Accepts up to two fetched instructions per cycle.
- Presents the two oldest entries to ID1 and retires 0/1/2 of them per cycle, as reported by ID1.
- Decouples fetch bandwidth from dual-issue consumption.
- Is emptied by branch and exception flushes.

Parameters:
- DEPTH, 8, number of entries; power of two, at least 4.
- PTR_W, 3, log2(DEPTH); pointer width.

Ports:
- clk, input, 1: clock; all state updates on its rising edge.
- rst, input, 1: asynchronous, active-low reset.
- flush, input, 1: branch-mispredict flush.
- exception_flush, input, 1: exception/eret flush.
- fetch_valid_0, input, 1: fetch slot 0 carries an instruction.
- fetch_valid_1, input, 1: fetch slot 1 carries an instruction. Legal only when fetch_valid_0=1.
- fetch_pc_0 / fetch_pc_1, input, 32: PCs.
- fetch_inst_0 / fetch_inst_1, input, 32: instruction words.
- fetch_adel_0 / fetch_adel_1, input, 1: instruction address-error flag.
- fetch_pred_taken_0 / fetch_pred_taken_1, input, 1: predictor taken bit.
- fetch_pred_target_0 / fetch_pred_target_1, input, 32: predicted target.
- fetch_ready, output, 1: queue has at least 2 free entries.
- issue_count, input, 2: entries consumed by ID1 this cycle (0, 1 or 2).
- out_valid_0 / out_valid_1, output, 1: oldest / second-oldest entry present.
- out_pc_0 / out_pc_1, output, 32: entry PC.
- out_inst_0 / out_inst_1, output, 32: entry instruction word.
- out_adel_0 / out_adel_1, output, 1: entry address-error flag.
- out_pred_taken_0 / out_pred_taken_1, output, 1: entry predictor taken bit.
- out_pred_target_0 / out_pred_target_1, output, 32: entry predicted target.
- count, output, PTR_W+1: current occupancy.

Behaviour:
- State:
  - storage array of DEPTH entries: {pc, inst, adel, pred_taken, pred_target};
  - head, tail: PTR_W bits, wrapping modulo DEPTH;
  - count register: PTR_W+1 bits.
- Reset (rst=0, asynchronous):
  - head=tail=count=0;
  - storage need not be reset;
  - all outputs read as 0 except fetch_ready=1.
- Outputs are combinational from head; zero extra latency.
  - out_valid_0 = (count>=1); out_valid_1 = (count>=2).
  - Slot 0 reads entry[head]; slot 1 reads entry[head+1 mod DEPTH].
  - Every out_* data field is forced to 0 when its valid bit is 0.
- fetch_ready = (DEPTH - count >= 2), computed from the registered count only; no combinational dependence on issue_count.
- Enqueue:
  - n_in = fetch_ready ? (fetch_valid_0 + (fetch_valid_0 & fetch_valid_1)) : 0.
  - Slot 0 writes entry[tail]; slot 1 writes entry[tail+1].
  - tail advances by n_in.
  - A fetch presented while fetch_ready=0 is ignored; fetch must hold it.
  - fetch_valid_1 without fetch_valid_0 is illegal: treat as n_in=0.
- Dequeue:
  - n_out = min(issue_count, count); an oversize issue_count is clamped; a simulation assertion fires.
  - head advances by n_out.
- Simultaneous enqueue/dequeue: count_next = count + n_in - n_out in the same cycle.
  - Full queue plus dequeue 2 still rejects the enqueue, because fetch_ready uses the old count.
- Entry-of-one boundary: n_in=2, n_out=1 at count=1 gives count=2. The new slot 0 is the old tail entry.
- Flush:
  - flush or exception_flush set head=tail=count=0 on the next edge.
  - Same-cycle enqueue and dequeue are discarded.
  - Outputs are invalid the following cycle.
  - Flush has priority over everything except reset.
- Reset mid-operation: queue empties immediately (asynchronous); no partial state survives.
- Invariant: 0 <= count <= DEPTH; (tail - head) mod DEPTH == count mod DEPTH.

Optional Feature:
- IQ_STATS_EN defined adds two output ports:
  - iq_dual_issue_cnt [31:0]: increments when n_out==2;
  - iq_empty_cnt [31:0]: increments each cycle count==0 and no flush.
  - Both counters wrap at 2^32, reset to 0 on rst, and are unaffected by flush.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset then idle → count=0, out_valid_0=out_valid_1=0, all out data 0, fetch_ready=1.
- Enqueue pc 0x1000/0x1004 with issue_count=0 → next cycle count=2, out_pc_0=0x1000, out_pc_1=0x1004, both valid.
- Fill to 8 with issue_count=0 → fetch_ready=0 at count=7 and 8. A further fetch pair is ignored; count stays 8.
- Wrap and simultaneous traffic:
  - stimulus: at count=7 with head=6, present 2 fetches; issue_count=2 each cycle for 3 cycles;
  - response: pointers wrap; PCs exit in strict program order; count stays constant once fetch_ready re-asserts.
- Flush collision: flush=1 together with enqueue of 2 and issue_count=1 at count=4 → next cycle count=0, out_valid_0=0. A subsequent enqueue appears at slot 0.
- Illegal issue_count: issue_count=2 at count=1 → count=0, head+1, assertion fires. Async rst pulse mid-traffic clears count without a clock edge.

Source files
------------

// File: rtl/inst_queue.sv
// inst_queue: dual-slot circular instruction queue between fetch and ID1.
// Up to two fetched instructions enter per cycle; the two oldest entries are
// presented combinationally to ID1, which retires 0, 1 or 2 of them per cycle.
// Branch and exception flushes empty the queue on the next clock edge.
// Optional build macro: IQ_STATS_EN adds dual-issue and empty-cycle counters.

module inst_queue #(
  parameter int DEPTH = 8,
  parameter int PTR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              exception_flush,
  input  logic              fetch_valid_0,
  input  logic              fetch_valid_1,
  input  logic [31:0]       fetch_pc_0,
  input  logic [31:0]       fetch_pc_1,
  input  logic [31:0]       fetch_inst_0,
  input  logic [31:0]       fetch_inst_1,
  input  logic              fetch_adel_0,
  input  logic              fetch_adel_1,
  input  logic              fetch_pred_taken_0,
  input  logic              fetch_pred_taken_1,
  input  logic [31:0]       fetch_pred_target_0,
  input  logic [31:0]       fetch_pred_target_1,
  output logic              fetch_ready,
  input  logic [1:0]        issue_count,
  output logic              out_valid_0,
  output logic              out_valid_1,
  output logic [31:0]       out_pc_0,
  output logic [31:0]       out_pc_1,
  output logic [31:0]       out_inst_0,
  output logic [31:0]       out_inst_1,
  output logic              out_adel_0,
  output logic              out_adel_1,
  output logic              out_pred_taken_0,
  output logic              out_pred_taken_1,
  output logic [31:0]       out_pred_target_0,
  output logic [31:0]       out_pred_target_1,
  output logic [PTR_W:0]    count
`ifdef IQ_STATS_EN
  ,
  output logic [31:0]       iq_dual_issue_cnt,
  output logic [31:0]       iq_empty_cnt
`endif
);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        adel;
    logic        pred_taken;
    logic [31:0] pred_target;
  } entry_t;

  // Highest occupancy that still leaves room for a full fetch pair.
  localparam logic [PTR_W:0] READY_MAX = (PTR_W+1)'(DEPTH - 2);

  entry_t           mem_q [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [PTR_W:0]   count_q, count_d;

  logic             flush_any_s;
  logic             fetch_ready_s;
  logic [1:0]       n_in_s;
  logic [1:0]       n_out_s;
  logic [1:0]       issue_lim_s;
  logic [PTR_W-1:0] head_p1_s;
  logic [PTR_W-1:0] tail_p1_s;
  entry_t           wr0_s, wr1_s;
  entry_t           rd0_s, rd1_s;

  assign flush_any_s   = flush | exception_flush;
  assign fetch_ready_s = (count_q <= READY_MAX);
  assign head_p1_s     = head_q + PTR_W'(1);
  assign tail_p1_s     = tail_q + PTR_W'(1);

  assign wr0_s = '{pc: fetch_pc_0, inst: fetch_inst_0, adel: fetch_adel_0,
                   pred_taken: fetch_pred_taken_0, pred_target: fetch_pred_target_0};
  assign wr1_s = '{pc: fetch_pc_1, inst: fetch_inst_1, adel: fetch_adel_1,
                   pred_taken: fetch_pred_taken_1, pred_target: fetch_pred_target_1};

  // Number of fetch slots accepted; slot 1 alone is malformed and dropped.
  always_comb begin
    n_in_s = 2'd0;
    if (fetch_ready_s && fetch_valid_0) begin
      n_in_s = fetch_valid_1 ? 2'd2 : 2'd1;
    end else begin
      n_in_s = 2'd0;
    end
  end

  // Number of entries retired: issue_count clamped to two slots and to occupancy.
  always_comb begin
    issue_lim_s = (issue_count > 2'd2) ? 2'd2 : issue_count;
    n_out_s     = issue_lim_s;
    if ((PTR_W+1)'(issue_lim_s) > count_q) begin
      n_out_s = count_q[1:0];
    end else begin
      n_out_s = issue_lim_s;
    end
  end

  // Pointer and occupancy next state; a flush overrides same-cycle traffic.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush_any_s) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      head_d  = head_q + PTR_W'(n_out_s);
      tail_d  = tail_q + PTR_W'(n_in_s);
      count_d = count_q + (PTR_W+1)'(n_in_s) - (PTR_W+1)'(n_out_s);
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage writes; contents are don't-care until covered by count.
  always_ff @(posedge clk) begin
    if (!flush_any_s && (n_in_s != 2'd0)) begin
      mem_q[tail_q] <= wr0_s;
      if (n_in_s == 2'd2) begin
        mem_q[tail_p1_s] <= wr1_s;
      end
    end
  end

  assign rd0_s = mem_q[head_q];
  assign rd1_s = mem_q[head_p1_s];

  // Present the two oldest entries, zeroing any slot that is not occupied.
  always_comb begin
    out_valid_0 = (count_q >= (PTR_W+1)'(1));
    out_valid_1 = (count_q >= (PTR_W+1)'(2));
    if (out_valid_0) begin
      out_pc_0          = rd0_s.pc;
      out_inst_0        = rd0_s.inst;
      out_adel_0        = rd0_s.adel;
      out_pred_taken_0  = rd0_s.pred_taken;
      out_pred_target_0 = rd0_s.pred_target;
    end else begin
      out_pc_0          = 32'd0;
      out_inst_0        = 32'd0;
      out_adel_0        = 1'b0;
      out_pred_taken_0  = 1'b0;
      out_pred_target_0 = 32'd0;
    end
    if (out_valid_1) begin
      out_pc_1          = rd1_s.pc;
      out_inst_1        = rd1_s.inst;
      out_adel_1        = rd1_s.adel;
      out_pred_taken_1  = rd1_s.pred_taken;
      out_pred_target_1 = rd1_s.pred_target;
    end else begin
      out_pc_1          = 32'd0;
      out_inst_1        = 32'd0;
      out_adel_1        = 1'b0;
      out_pred_taken_1  = 1'b0;
      out_pred_target_1 = 32'd0;
    end
  end

  assign fetch_ready = fetch_ready_s;
  assign count       = count_q;

`ifdef IQ_STATS_EN
  logic [31:0] dual_cnt_q;
  logic [31:0] empty_cnt_q;

  // Statistics counters; they wrap freely and ignore flushes except for gating empty cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dual_cnt_q  <= 32'd0;
      empty_cnt_q <= 32'd0;
    end else begin
      if (n_out_s == 2'd2) begin
        dual_cnt_q <= dual_cnt_q + 32'd1;
      end
      if ((count_q == '0) && !flush_any_s) begin
        empty_cnt_q <= empty_cnt_q + 32'd1;
      end
    end
  end

  assign iq_dual_issue_cnt = dual_cnt_q;
  assign iq_empty_cnt      = empty_cnt_q;
`endif

`ifndef SYNTHESIS
  inst_queue_chk #(.PTR_W(PTR_W)) u_chk (
    .clk         (clk),
    .rst         (rst),
    .issue_count (issue_count),
    .count       (count_q)
  );
`endif

endmodule

// inst_queue_chk: simulation-only checks on the ID1 retire handshake.
module inst_queue_chk #(
  parameter int PTR_W = 3
) (
  input logic             clk,
  input logic             rst,
  input logic [1:0]       issue_count,
  input logic [PTR_W:0]   count
);

  // Warn when ID1 claims more entries than are presented; the queue clamps it.
  always_ff @(posedge clk) begin
    if (rst) begin
      assert ((issue_count <= 2'd2) && ((PTR_W+1)'(issue_count) <= count))
        else $warning("inst_queue: issue_count %0d exceeds occupancy %0d, clamped",
                      issue_count, count);
    end
  end

endmodule

// File: tb/tb_inst_queue.sv
// tb_inst_queue: directed vectors with hand-computed expected queue views.
// The driver applies one vector per cycle and queues the expected post-edge
// view; a monitor pops and compares it one step after each rising edge.

module tb_inst_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush, exception_flush;
  logic        fetch_valid_0, fetch_valid_1;
  logic [31:0] fetch_pc_0, fetch_pc_1, fetch_inst_0, fetch_inst_1;
  logic        fetch_adel_0, fetch_adel_1, fetch_pred_taken_0, fetch_pred_taken_1;
  logic [31:0] fetch_pred_target_0, fetch_pred_target_1;
  logic        fetch_ready;
  logic [1:0]  issue_count;
  logic        out_valid_0, out_valid_1;
  logic [31:0] out_pc_0, out_pc_1, out_inst_0, out_inst_1;
  logic        out_adel_0, out_adel_1, out_pred_taken_0, out_pred_taken_1;
  logic [31:0] out_pred_target_0, out_pred_target_1;
  logic [3:0]  count;
`ifdef IQ_STATS_EN
  logic [31:0] iq_dual_issue_cnt, iq_empty_cnt;
`endif

  always #5 clk = ~clk;

  inst_queue #(.DEPTH(8), .PTR_W(3)) dut (
    .clk(clk), .rst(rst), .flush(flush), .exception_flush(exception_flush),
    .fetch_valid_0(fetch_valid_0), .fetch_valid_1(fetch_valid_1),
    .fetch_pc_0(fetch_pc_0), .fetch_pc_1(fetch_pc_1),
    .fetch_inst_0(fetch_inst_0), .fetch_inst_1(fetch_inst_1),
    .fetch_adel_0(fetch_adel_0), .fetch_adel_1(fetch_adel_1),
    .fetch_pred_taken_0(fetch_pred_taken_0), .fetch_pred_taken_1(fetch_pred_taken_1),
    .fetch_pred_target_0(fetch_pred_target_0), .fetch_pred_target_1(fetch_pred_target_1),
    .fetch_ready(fetch_ready), .issue_count(issue_count),
    .out_valid_0(out_valid_0), .out_valid_1(out_valid_1),
    .out_pc_0(out_pc_0), .out_pc_1(out_pc_1),
    .out_inst_0(out_inst_0), .out_inst_1(out_inst_1),
    .out_adel_0(out_adel_0), .out_adel_1(out_adel_1),
    .out_pred_taken_0(out_pred_taken_0), .out_pred_taken_1(out_pred_taken_1),
    .out_pred_target_0(out_pred_target_0), .out_pred_target_1(out_pred_target_1),
    .count(count)
`ifdef IQ_STATS_EN
    , .iq_dual_issue_cnt(iq_dual_issue_cnt), .iq_empty_cnt(iq_empty_cnt)
`endif
  );

  typedef struct {
    logic        fv0;
    logic        fv1;
    logic [31:0] pc0;
    logic [31:0] pc1;
    logic [1:0]  iss;
    logic        fl;
    logic        efl;
    int          ecnt;
    logic [31:0] epc0;
    logic [31:0] epc1;
    logic        erdy;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  // Fixed side-field encoding for every fetched instruction.
  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return ~pc;
  endfunction
  function automatic logic [31:0] tgt_of(input logic [31:0] pc);
    return pc + 32'h0000_0100;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_view(input int ecnt, input logic [31:0] epc0,
                            input logic [31:0] epc1, input logic erdy);
    logic v0, v1;
    v0 = (ecnt >= 1);
    v1 = (ecnt >= 2);
    chk("count",       32'(count),        32'(ecnt));
    chk("fetch_ready", 32'(fetch_ready),  32'(erdy));
    chk("out_valid_0", 32'(out_valid_0),  32'(v0));
    chk("out_valid_1", 32'(out_valid_1),  32'(v1));
    chk("out_pc_0",    out_pc_0,          epc0);
    chk("out_pc_1",    out_pc_1,          epc1);
    chk("out_inst_0",  out_inst_0,        v0 ? inst_of(epc0) : 32'd0);
    chk("out_inst_1",  out_inst_1,        v1 ? inst_of(epc1) : 32'd0);
    chk("out_adel_0",  32'(out_adel_0),   32'(v0 & epc0[2]));
    chk("out_adel_1",  32'(out_adel_1),   32'(v1 & epc1[2]));
    chk("out_taken_0", 32'(out_pred_taken_0), 32'(v0 & epc0[3]));
    chk("out_taken_1", 32'(out_pred_taken_1), 32'(v1 & epc1[3]));
    chk("out_tgt_0",   out_pred_target_0, v0 ? tgt_of(epc0) : 32'd0);
    chk("out_tgt_1",   out_pred_target_1, v1 ? tgt_of(epc1) : 32'd0);
  endtask

  task automatic add(input logic fv0, input logic fv1, input logic [31:0] pc0,
                     input logic [31:0] pc1, input logic [1:0] iss, input logic fl,
                     input logic efl, input int ecnt, input logic [31:0] epc0,
                     input logic [31:0] epc1, input logic erdy);
    vec_t v;
    v = '{fv0, fv1, pc0, pc1, iss, fl, efl, ecnt, epc0, epc1, erdy};
    vecs.push_back(v);
  endtask

  task automatic drive(input vec_t v);
    fetch_valid_0       = v.fv0;
    fetch_valid_1       = v.fv1;
    fetch_pc_0          = v.pc0;
    fetch_pc_1          = v.pc1;
    fetch_inst_0        = inst_of(v.pc0);
    fetch_inst_1        = inst_of(v.pc1);
    fetch_adel_0        = v.pc0[2];
    fetch_adel_1        = v.pc1[2];
    fetch_pred_taken_0  = v.pc0[3];
    fetch_pred_taken_1  = v.pc1[3];
    fetch_pred_target_0 = tgt_of(v.pc0);
    fetch_pred_target_1 = tgt_of(v.pc1);
    issue_count         = v.iss;
    flush               = v.fl;
    exception_flush     = v.efl;
  endtask

  task automatic apply_all();
    vec_t v;
    while (vecs.size() != 0) begin
      v = vecs.pop_front();
      @(negedge clk);
      drive(v);
      exp_q.push_back(v);
    end
    @(negedge clk);
    v = '{1'b0, 1'b0, 32'd0, 32'd0, 2'd0, 1'b0, 1'b0, 0, 32'd0, 32'd0, 1'b1};
    drive(v);
  endtask

  task automatic drain();
    for (int i = 0; i < 6 && exp_q.size() != 0; i++) @(posedge clk);
    #2;
    n_vec++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expected views pending, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // Monitor: compare the queued expected view one step after each rising edge.
  initial begin
    vec_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check_view(e.ecnt, e.epc0, e.epc1, e.erdy);
      end
    end
  end

  initial begin
    vec_t idle;
    idle = '{1'b0, 1'b0, 32'd0, 32'd0, 2'd0, 1'b0, 1'b0, 0, 32'd0, 32'd0, 1'b1};
    drive(idle);
    rst = 1'b0;
    #2;
    check_view(0, 32'd0, 32'd0, 1'b1);
    #5;
    rst = 1'b1;

    //  fv0   fv1   pc0           pc1           iss   fl    efl   cnt epc0          epc1          rdy
    add(1'b0, 1'b0, 32'h0,        32'h0,        2'd0, 1'b0, 1'b0, 0, 32'h0,        32'h0,        1'b1);
    add(1'b1, 1'b1, 32'h1000,     32'h1004,     2'd0, 1'b0, 1'b0, 2, 32'h1000,     32'h1004,     1'b1);
    add(1'b1, 1'b1, 32'h1008,     32'h100C,     2'd0, 1'b0, 1'b0, 4, 32'h1000,     32'h1004,     1'b1);
    add(1'b1, 1'b1, 32'h1010,     32'h1014,     2'd0, 1'b0, 1'b0, 6, 32'h1000,     32'h1004,     1'b1);
    add(1'b1, 1'b1, 32'h1018,     32'h101C,     2'd0, 1'b0, 1'b0, 8, 32'h1000,     32'h1004,     1'b0);
    add(1'b1, 1'b1, 32'h1020,     32'h1024,     2'd0, 1'b0, 1'b0, 8, 32'h1000,     32'h1004,     1'b0);
    add(1'b1, 1'b1, 32'h1020,     32'h1024,     2'd1, 1'b0, 1'b0, 7, 32'h1004,     32'h1008,     1'b0);
    add(1'b1, 1'b1, 32'h1020,     32'h1024,     2'd2, 1'b0, 1'b0, 5, 32'h100C,     32'h1010,     1'b1);
    add(1'b1, 1'b1, 32'h1020,     32'h1024,     2'd2, 1'b0, 1'b0, 5, 32'h1014,     32'h1018,     1'b1);
    add(1'b1, 1'b1, 32'h1028,     32'h102C,     2'd1, 1'b0, 1'b0, 6, 32'h1018,     32'h101C,     1'b1);
    add(1'b1, 1'b0, 32'h1030,     32'h0,        2'd0, 1'b0, 1'b0, 7, 32'h1018,     32'h101C,     1'b0);
    add(1'b1, 1'b1, 32'h1034,     32'h1038,     2'd2, 1'b0, 1'b0, 5, 32'h1020,     32'h1024,     1'b1);
    add(1'b1, 1'b1, 32'h1034,     32'h1038,     2'd2, 1'b0, 1'b0, 5, 32'h1028,     32'h102C,     1'b1);
    add(1'b1, 1'b1, 32'h103C,     32'h1040,     2'd2, 1'b0, 1'b0, 5, 32'h1030,     32'h1034,     1'b1);
    add(1'b0, 1'b0, 32'h0,        32'h0,        2'd1, 1'b0, 1'b0, 4, 32'h1034,     32'h1038,     1'b1);
    add(1'b1, 1'b1, 32'h1044,     32'h1048,     2'd1, 1'b1, 1'b0, 0, 32'h0,        32'h0,        1'b1);
    add(1'b1, 1'b1, 32'h2000,     32'h2004,     2'd0, 1'b0, 1'b0, 2, 32'h2000,     32'h2004,     1'b1);
    add(1'b1, 1'b1, 32'h3000,     32'h3004,     2'd2, 1'b0, 1'b1, 0, 32'h0,        32'h0,        1'b1);
    add(1'b1, 1'b0, 32'h2008,     32'h0,        2'd0, 1'b0, 1'b0, 1, 32'h2008,     32'h0,        1'b1);
    add(1'b1, 1'b1, 32'h200C,     32'h2010,     2'd1, 1'b0, 1'b0, 2, 32'h200C,     32'h2010,     1'b1);
    add(1'b0, 1'b0, 32'h0,        32'h0,        2'd2, 1'b0, 1'b0, 0, 32'h0,        32'h0,        1'b1);
    add(1'b1, 1'b0, 32'h2014,     32'h0,        2'd0, 1'b0, 1'b0, 1, 32'h2014,     32'h0,        1'b1);
    add(1'b0, 1'b0, 32'h0,        32'h0,        2'd2, 1'b0, 1'b0, 0, 32'h0,        32'h0,        1'b1);
    add(1'b1, 1'b1, 32'h2018,     32'h201C,     2'd0, 1'b0, 1'b0, 2, 32'h2018,     32'h201C,     1'b1);
    add(1'b0, 1'b1, 32'h2020,     32'h2024,     2'd0, 1'b0, 1'b0, 2, 32'h2018,     32'h201C,     1'b1);
    apply_all();
    drain();

    // Asynchronous reset pulse mid-cycle with two entries held.
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check_view(0, 32'd0, 32'd0, 1'b1);
    @(negedge clk);
    rst = 1'b1;

    add(1'b0, 1'b0, 32'h0,        32'h0,        2'd0, 1'b0, 1'b0, 0, 32'h0,        32'h0,        1'b1);
    add(1'b1, 1'b1, 32'h4000,     32'h4004,     2'd0, 1'b0, 1'b0, 2, 32'h4000,     32'h4004,     1'b1);
    add(1'b0, 1'b0, 32'h0,        32'h0,        2'd2, 1'b0, 1'b0, 0, 32'h0,        32'h0,        1'b1);
    apply_all();
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
